// File: rtl/mux_unstriping_pkg.sv
// Shared PHY lane definitions used by the striping and un-striping datapath blocks.
// Provides the default word width, lane count and lane-select encoding.
package mux_unstriping_pkg;

   localparam int PHY_DATA_W = 32;
   localparam int LANE_NUM   = 2;

   typedef enum logic {
      LANE0 = 1'b0,
      LANE1 = 1'b1
   } lane_sel_e;

   function automatic lane_sel_e next_lane(input lane_sel_e cur);
      return (cur == LANE0) ? LANE1 : LANE0;
   endfunction

endpackage

// File: rtl/mux_unstriping_if.sv
// Lane-input / ordered-output bundle for mux_unstriping.
// err_cnt exists only when UNSTRIPE_ERR_CNT_EN is defined.
interface mux_unstriping_if
   import mux_unstriping_pkg::*;
#(
   parameter int DATA_W = PHY_DATA_W
`ifdef UNSTRIPE_ERR_CNT_EN
   ,parameter int CNT_W = 8
`endif
);

   logic [DATA_W-1:0] lane_0;
   logic              valid_in0;
   logic [DATA_W-1:0] lane_1;
   logic              valid_in1;
   logic              ready_out;
   logic [DATA_W-1:0] data_out;
   logic              valid_out;
   logic              overflow0;
   logic              overflow1;
`ifdef UNSTRIPE_ERR_CNT_EN
   logic [CNT_W-1:0]  err_cnt;
`endif

   modport master (
      output lane_0, valid_in0, lane_1, valid_in1, ready_out,
      input  data_out, valid_out, overflow0, overflow1
`ifdef UNSTRIPE_ERR_CNT_EN
      ,input err_cnt
`endif
   );

   modport slave (
      input  lane_0, valid_in0, lane_1, valid_in1, ready_out,
      output data_out, valid_out, overflow0, overflow1
`ifdef UNSTRIPE_ERR_CNT_EN
      ,output err_cnt
`endif
   );

endinterface

// File: rtl/mux_unstriping_lane_fifo.sv
// Per-lane synchronous FIFO; pointers carry one extra wrap bit to tell full from empty.
// Simultaneous push and pop are both honoured, including when full.
module lane_fifo #(
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4
)(
   input  logic              clk_2f,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] din,
   input  logic              pop,
   output logic [DATA_W-1:0] head,
   output logic              empty,
   output logic              full
);

   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int PTR_W = AW + 1;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk_2f) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   // On push-while-full-with-pop the written slot is the one being popped; head is sampled first.
   always_ff @(posedge clk_2f) begin
      if (push && !reset) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/mux_unstriping.sv
// Two-lane receive un-striping: merges lane FIFOs into one stream alternating lane 0, lane 1.
// Optional dropped-word counter enabled by defining UNSTRIPE_ERR_CNT_EN.
module mux_unstriping
   import mux_unstriping_pkg::*;
#(
   parameter int DATA_W     = PHY_DATA_W,
   parameter int FIFO_DEPTH = 4
`ifdef UNSTRIPE_ERR_CNT_EN
   ,parameter int CNT_W     = 8
`endif
)(
   input  logic            clk_2f,
   input  logic            reset,
   mux_unstriping_if.slave bus
);

   logic [DATA_W-1:0]   lane_d [LANE_NUM];
   logic [DATA_W-1:0]   head   [LANE_NUM];
   logic [LANE_NUM-1:0] lane_v;
   logic [LANE_NUM-1:0] push;
   logic [LANE_NUM-1:0] pop;
   logic [LANE_NUM-1:0] drop;
   logic [LANE_NUM-1:0] empty;
   logic [LANE_NUM-1:0] full;
   logic [LANE_NUM-1:0] ovf;
   logic                out_free;
   lane_sel_e           sel;
   logic [DATA_W-1:0]   data_p0;
   logic                vld_p0;

   assign lane_d[0] = bus.lane_0;
   assign lane_d[1] = bus.lane_1;
   assign lane_v    = {bus.valid_in1, bus.valid_in0};
   assign out_free  = !vld_p0 || bus.ready_out;

   // Only the expected lane may be popped, so a waiting lane 1 word never overtakes lane 0.
   always_comb begin
      pop = '0;
      if (out_free && !empty[sel]) pop[sel] = 1'b1;
   end

   always_comb begin
      push = lane_v & (~full | pop);
      drop = lane_v & full & ~pop;
   end

   for (genvar g = 0; g < LANE_NUM; g++) begin : g_lane
      lane_fifo #(
         .DATA_W     (DATA_W),
         .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk_2f (clk_2f),
         .reset  (reset),
         .push   (push[g]),
         .din    (lane_d[g]),
         .pop    (pop[g]),
         .head   (head[g]),
         .empty  (empty[g]),
         .full   (full[g])
      );
   end

   // Stage p0: registered output word
   always_ff @(posedge clk_2f) begin
      if (reset) begin
         data_p0 <= '0;
         vld_p0  <= 1'b0;
         sel     <= LANE0;
      end else if (out_free) begin
         if (!empty[sel]) begin
            data_p0 <= head[sel];
            vld_p0  <= 1'b1;
            sel     <= next_lane(sel);
         end else begin
            vld_p0  <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_2f) begin
      if (reset) ovf <= '0;
      else       ovf <= ovf | drop;
   end

   assign bus.data_out  = data_p0;
   assign bus.valid_out = vld_p0;
   assign bus.overflow0 = ovf[0];
   assign bus.overflow1 = ovf[1];

`ifdef UNSTRIPE_ERR_CNT_EN
   logic [CNT_W-1:0] err_cnt_q;
   logic [1:0]       drop_n;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] acc,
                                                input logic [1:0]       inc);
      logic [CNT_W:0] sum;
      sum = {1'b0, acc} + {{(CNT_W-1){1'b0}}, inc};
      return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   endfunction

   assign drop_n = {1'b0, drop[0]} + {1'b0, drop[1]};

   always_ff @(posedge clk_2f) begin
      if (reset) err_cnt_q <= '0;
      else       err_cnt_q <= sat_add(err_cnt_q, drop_n);
   end

   assign bus.err_cnt = err_cnt_q;
`endif

endmodule
